// File: rtl/dec_fwd_scoreboard.sv
// dec_fwd_scoreboard
//   Decode-stage forwarding and load-use hazard unit. A shift-register scoreboard
//   holds the instructions in flight in stages 1..DEPTH after decode (1=EXE, 2=MEM, ...).
//   For each decode source operand, the youngest matching producer is selected.
//   A load whose data is not yet forwardable stalls decode until it drains far enough.
//
// Ports
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   dec_valid      valid instruction in decode
//   dec_rs         NUM_SRC packed source addresses, operand i at [i*REG_AW +: REG_AW]
//   dec_src_used   per-operand "actually read" flags
//   dec_we/wa      decode instruction register write enable / address
//   dec_is_load    decode instruction is a load
//   flush          kill the decode instruction
//   fwd_sel        per-operand select: 0=regfile, 2k-1=ALU result at stage k,
//                  2k=load data at stage k
//   stall          hold PC and IF/ID
//   issue          decode instruction enters EXE this cycle
//
// Optional feature (macro HAZARD_STATS_EN)
//   stats_clr      synchronous clear of both counters (wins over increment)
//   stall_cnt      saturating count of stall cycles
//   fwd_cnt        saturating count of issue cycles with any non-zero fwd_sel

module dec_fwd_scoreboard #(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned NUM_SRC  = 2,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned LOAD_LAT = 2,
  parameter int unsigned SEL_W    = $clog2(2 * DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      dec_valid,
  input  logic [NUM_SRC*REG_AW-1:0] dec_rs,
  input  logic [NUM_SRC-1:0]        dec_src_used,
  input  logic                      dec_we,
  input  logic [REG_AW-1:0]         dec_wa,
  input  logic                      dec_is_load,
  input  logic                      flush,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
  output logic                      stall,
`ifdef HAZARD_STATS_EN
  input  logic                      stats_clr,
  output logic [31:0]               stall_cnt,
  output logic [31:0]               fwd_cnt,
`endif
  output logic                      issue
);

  // Entry index j holds stage k = j+1.
  logic [DEPTH-1:0]             v_q, v_d;
  logic [DEPTH-1:0]             we_q, we_d;
  logic [DEPTH-1:0]             ld_q, ld_d;
  logic [DEPTH-1:0][REG_AW-1:0] wa_q, wa_d;

  logic             hazard;
  logic [SEL_W-1:0] sel;
  logic             haz_op;
  logic [REG_AW-1:0] rs;

  // Operand select: walk from oldest to youngest so the youngest match is written last.
  always_comb begin
    fwd_sel = '0;
    hazard  = 1'b0;
    sel     = '0;
    haz_op  = 1'b0;
    rs      = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      sel    = '0;
      haz_op = 1'b0;
      rs     = dec_rs[i*REG_AW +: REG_AW];
      for (int k = int'(DEPTH); k >= 1; k--) begin
        if (v_q[k-1] && we_q[k-1] && (wa_q[k-1] == rs) && (rs != '0) &&
            dec_src_used[i] && dec_valid) begin
          if (ld_q[k-1] && (k < int'(LOAD_LAT))) begin
            sel    = '0;
            haz_op = 1'b1;
          end else if (ld_q[k-1]) begin
            sel    = SEL_W'(2 * k);
            haz_op = 1'b0;
          end else begin
            sel    = SEL_W'(2 * k - 1);
            haz_op = 1'b0;
          end
        end
      end
      fwd_sel[i*SEL_W +: SEL_W] = sel;
      hazard = hazard | haz_op;
    end
  end

  assign stall = hazard & ~flush;
  assign issue = dec_valid & ~stall & ~flush;

  // Stage 1 takes the issuing instruction or a bubble; the rest simply shift.
  always_comb begin
    v_d  = v_q;
    we_d = we_q;
    ld_d = ld_q;
    wa_d = wa_q;
    v_d[0]  = issue;
    we_d[0] = issue & dec_we;
    ld_d[0] = issue & dec_is_load;
    wa_d[0] = issue ? dec_wa : '0;
    for (int j = 1; j < int'(DEPTH); j++) begin
      v_d[j]  = v_q[j-1];
      we_d[j] = we_q[j-1];
      ld_d[j] = ld_q[j-1];
      wa_d[j] = wa_q[j-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q  <= '0;
      we_q <= '0;
      ld_q <= '0;
      wa_q <= '0;
    end else begin
      v_q  <= v_d;
      we_q <= we_d;
      ld_q <= ld_d;
      wa_q <= wa_d;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] fwd_cnt_q, fwd_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (stats_clr) begin
      stall_cnt_d = '0;
      fwd_cnt_d   = '0;
    end else begin
      if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_d = stall_cnt_q + 32'd1;
      end
      if (issue && (fwd_sel != '0) && (fwd_cnt_q != 32'hFFFF_FFFF)) begin
        fwd_cnt_d = fwd_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_dec_fwd_scoreboard.sv
// Self-checking bench for dec_fwd_scoreboard (NUM_SRC=2, DEPTH=2, LOAD_LAT=2).
// Expected outputs are queued as each stimulus vector is driven and popped when
// the combinational outputs are sampled, before the next rising edge.

module tb_dec_fwd_scoreboard;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned NUM_SRC = 2;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned LOAD_LAT = 2;
  localparam int unsigned SEL_W = 3;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      dec_valid;
  logic [NUM_SRC*REG_AW-1:0] dec_rs;
  logic [NUM_SRC-1:0]        dec_src_used;
  logic                      dec_we;
  logic [REG_AW-1:0]         dec_wa;
  logic                      dec_is_load;
  logic                      flush;
  logic [NUM_SRC*SEL_W-1:0]  fwd_sel;
  logic                      stall;
  logic                      issue;
`ifdef HAZARD_STATS_EN
  logic                      stats_clr;
  logic [31:0]               stall_cnt;
  logic [31:0]               fwd_cnt;
`endif

  dec_fwd_scoreboard #(
    .REG_AW  (REG_AW),
    .NUM_SRC (NUM_SRC),
    .DEPTH   (DEPTH),
    .LOAD_LAT(LOAD_LAT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dec_valid   (dec_valid),
    .dec_rs      (dec_rs),
    .dec_src_used(dec_src_used),
    .dec_we      (dec_we),
    .dec_wa      (dec_wa),
    .dec_is_load (dec_is_load),
    .flush       (flush),
    .fwd_sel     (fwd_sel),
    .stall       (stall),
`ifdef HAZARD_STATS_EN
    .stats_clr   (stats_clr),
    .stall_cnt   (stall_cnt),
    .fwd_cnt     (fwd_cnt),
`endif
    .issue       (issue)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [2:0] sel0;
    logic [2:0] sel1;
    logic       stl;
    logic       iss;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                       input logic [1:0] used, input logic we, input logic [4:0] wa,
                       input logic ld, input logic fl);
    dec_valid    = v;
    dec_rs       = {rs1, rs0};
    dec_src_used = used;
    dec_we       = we;
    dec_wa       = wa;
    dec_is_load  = ld;
    flush        = fl;
  endtask

  task automatic expect_out(input string tag, input logic [2:0] s0, input logic [2:0] s1,
                            input logic st, input logic is);
    exp_t e;
    e.tag  = tag;
    e.sel0 = s0;
    e.sel1 = s1;
    e.stl  = st;
    e.iss  = is;
    exp_q.push_back(e);
  endtask

  task automatic compare_out();
    exp_t e;
    if (exp_q.size() == 0) begin
      check_eq("queue_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_eq({e.tag, ".sel0"}, 32'(fwd_sel[2:0]), 32'(e.sel0));
      check_eq({e.tag, ".sel1"}, 32'(fwd_sel[5:3]), 32'(e.sel1));
      check_eq({e.tag, ".stall"}, 32'(stall), 32'(e.stl));
      check_eq({e.tag, ".issue"}, 32'(issue), 32'(e.iss));
    end
  endtask

  // Drive one decode cycle (called just after a falling edge), sample before the rising edge.
  task automatic step(input string tag, input logic v, input logic [4:0] rs0,
                      input logic [4:0] rs1, input logic [1:0] used, input logic we,
                      input logic [4:0] wa, input logic ld, input logic fl,
                      input logic [2:0] s0, input logic [2:0] s1, input logic st,
                      input logic is);
    drive(v, rs0, rs1, used, we, wa, ld, fl);
    expect_out(tag, s0, s1, st, is);
    #1;
    compare_out();
    @(negedge clk);
  endtask

  initial begin
`ifdef HAZARD_STATS_EN
    stats_clr = 1'b0;
`endif
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    // In reset: no forwarding, no stall, issue follows dec_valid.
    step("reset", 1, 5'd5, 5'd5, 2'b11, 1, 5'd5, 1, 0, 3'd0, 3'd0, 0, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // ALU producer at stage 1, then stage 2, and an unused operand.
    step("alu_wa5",  1, 5'd0, 5'd0, 2'b00, 1, 5'd5, 0, 0, 3'd0, 3'd0, 0, 1);
    step("fwd_e1",   1, 5'd5, 5'd0, 2'b01, 0, 5'd0, 0, 0, 3'd1, 3'd0, 0, 1);
    step("fwd_e2",   1, 5'd5, 5'd5, 2'b10, 0, 5'd0, 0, 0, 3'd0, 3'd3, 0, 1);

    // Load-use: one bubble, then load data from stage 2.
    step("load_wa7", 1, 5'd0, 5'd0, 2'b00, 1, 5'd7, 1, 0, 3'd0, 3'd0, 0, 1);
    step("lu_stall", 1, 5'd7, 5'd0, 2'b01, 0, 5'd0, 0, 0, 3'd0, 3'd0, 1, 0);
    step("lu_rel",   1, 5'd7, 5'd0, 2'b01, 0, 5'd0, 0, 0, 3'd4, 3'd0, 0, 1);

    // Youngest wins, r0 never forwards.
    step("alu9_a",   1, 5'd0, 5'd0, 2'b00, 1, 5'd9, 0, 0, 3'd0, 3'd0, 0, 1);
    step("alu9_b",   1, 5'd9, 5'd0, 2'b01, 1, 5'd9, 0, 0, 3'd1, 3'd0, 0, 1);
    step("young",    1, 5'd9, 5'd9, 2'b11, 1, 5'd0, 0, 0, 3'd1, 3'd1, 0, 1);
    step("r0_none",  1, 5'd0, 5'd9, 2'b11, 0, 5'd0, 0, 0, 3'd0, 3'd3, 0, 1);

    // Invalid decode never matches or issues.
    step("invalid",  0, 5'd9, 5'd0, 2'b01, 0, 5'd0, 0, 0, 3'd0, 3'd0, 0, 0);

    // Flush over a load-use hazard; the flushed writer of r3 must not enter stage 1.
    step("load_wa3", 1, 5'd0, 5'd0, 2'b00, 1, 5'd3, 1, 0, 3'd0, 3'd0, 0, 1);
    step("flush",    1, 5'd3, 5'd0, 2'b01, 1, 5'd3, 0, 1, 3'd0, 3'd0, 0, 0);
    step("post_fl",  1, 5'd3, 5'd0, 2'b01, 0, 5'd0, 0, 0, 3'd4, 3'd0, 0, 1);

    // Self-forward check: writer and reader of r6 in the same decode slot.
    step("self",     1, 5'd6, 5'd0, 2'b01, 1, 5'd6, 0, 0, 3'd0, 3'd0, 0, 1);

    // Reset asserted mid-stall drops the hazard immediately.
    step("load_wa4", 1, 5'd0, 5'd0, 2'b00, 1, 5'd4, 1, 0, 3'd0, 3'd0, 0, 1);
    drive(1'b1, 5'd4, 5'd0, 2'b01, 1'b0, 5'd0, 1'b0, 1'b0);
    expect_out("pre_rst", 3'd0, 3'd0, 1, 0);
    #1;
    compare_out();
    rst_n = 1'b0;
    expect_out("mid_rst", 3'd0, 3'd0, 0, 1);
    #1;
    compare_out();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    expect_out("after_rst", 3'd0, 3'd0, 0, 1);
    compare_out();
    @(negedge clk);
    step("cleared",  1, 5'd4, 5'd0, 2'b01, 0, 5'd0, 0, 0, 3'd0, 3'd0, 0, 1);

`ifdef HAZARD_STATS_EN
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    for (int n = 0; n < 3; n++) begin
      step("st_load", 1, 5'd0, 5'd0, 2'b00, 1, 5'd8, 1, 0, 3'd0, 3'd0, 0, 1);
      step("st_stall", 1, 5'd8, 5'd0, 2'b01, 0, 5'd0, 0, 0, 3'd0, 3'd0, 1, 0);
      step("st_rel", 1, 5'd8, 5'd0, 2'b01, 0, 5'd0, 0, 0, 3'd4, 3'd0, 0, 1);
    end
    drive(1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    check_eq("stall_cnt", stall_cnt, 32'd3);
    check_eq("fwd_cnt", fwd_cnt, 32'd3);
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    check_eq("stall_clr", stall_cnt, 32'd0);
    check_eq("fwd_clr", fwd_cnt, 32'd0);
`endif

    if (exp_q.size() != 0) check_eq("queue_left", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
